// File: rtl/viterbi_pkg.sv
// Shared convolutional-code definitions: default generators, encoder FSM states
// and the generator/parity helper used by both the encoder and the decoder.
package viterbi_pkg;

    localparam int unsigned K_DEF  = 3;
    localparam int unsigned K_MAX  = 32;

    localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
    localparam logic [K_DEF-1:0] G1_DEF = 3'b101;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } enc_state_t;

    // Parity of the register taps selected by generator g.
    function automatic logic parity(input logic [K_MAX-1:0] g, input logic [K_MAX-1:0] v);
        return ^(g & v);
    endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with optional zero-tail
// termination and a single valid/ready output register stage.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int unsigned  K         = K_DEF,
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF,
    parameter bit           TERMINATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last
);

    localparam int unsigned MW  = K - 1;
    localparam int unsigned TCW = (K > 1) ? $clog2(K) : 1;
    localparam logic [TCW-1:0] TAIL_LAST = TCW'(K - 2);

    enc_state_t     state;
    enc_state_t     state_nxt;
    logic [MW-1:0]  sr;
    logic [MW-1:0]  sr_nxt;
    logic [TCW-1:0] tail_cnt;
    logic [TCW-1:0] tail_cnt_nxt;

    logic           slot_free;
    logic           accept;
    logic           tail_load;
    logic           tail_done;
    logic           load;
    logic           u;
    logic [K-1:0]   v;
    logic [1:0]     sym_nxt;
    logic           last_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DATA;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DATA: if (accept && in_last && TERMINATE) state_nxt = TAIL;
            TAIL: if (tail_done)                      state_nxt = DATA;
            default:                                  state_nxt = DATA;
        endcase
    end

    // FSM outputs: handshake and load qualifiers
    always_comb begin
        slot_free = 1'b0;
        in_ready  = 1'b0;
        accept    = 1'b0;
        tail_load = 1'b0;
        tail_done = 1'b0;

        slot_free = !out_valid || out_ready;
        in_ready  = enable && (state == DATA) && slot_free;
        accept    = in_valid && in_ready;
        tail_load = enable && (state == TAIL) && slot_free;
        tail_done = tail_load && (tail_cnt == TAIL_LAST);
    end

    // Encoder datapath: tap vector, parities, shift-register and tail-counter updates
    always_comb begin
        load         = accept || tail_load;
        u            = accept ? in_bit : 1'b0;
        v            = '0;
        sr_nxt       = sr;
        tail_cnt_nxt = tail_cnt;
        last_nxt     = 1'b0;

        v[K-1] = u;
        for (int i = 0; i < int'(MW); i++) begin
            v[K-2-i] = sr[i];
        end

        sym_nxt = {parity(K_MAX'(G0), K_MAX'(v)), parity(K_MAX'(G1), K_MAX'(v))};

        if (TERMINATE) begin
            last_nxt = tail_done;
        end else begin
            last_nxt = accept && in_last;
        end

        if (load) begin
            sr_nxt[0] = u;
            for (int i = 1; i < int'(MW); i++) begin
                sr_nxt[i] = sr[i-1];
            end
        end
        // Unterminated frames still start the next frame from the zero state
        if (!TERMINATE && accept && in_last) begin
            sr_nxt = '0;
        end

        if (state == TAIL) begin
            if (tail_done) begin
                tail_cnt_nxt = '0;
            end else if (tail_load) begin
                tail_cnt_nxt = tail_cnt + TCW'(1);
            end
        end else begin
            tail_cnt_nxt = '0;
        end
    end

    // Shift register, tail counter and output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            sr       <= sr_nxt;
            tail_cnt <= tail_cnt_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_sym   <= sym_nxt;
                out_last  <= last_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: terminated (K=3, 7/5) and unterminated instances.
module tb_conv_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic       in_bit;
    logic       in_last;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic       out_last;

    logic       in_valid_nt;
    logic       in_ready_nt;
    logic       out_valid_nt;
    logic [1:0] out_sym_nt;
    logic       out_last_nt;

    int n_run  = 0;
    int n_fail = 0;

    logic [2:0] q[$];

    // {out_last, out_sym} for frame 1,0,1,1 with two zero tail bits
    localparam logic [2:0] EXP_A [6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};

    always #5 clk = ~clk;

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TERMINATE(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last)
    );

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TERMINATE(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid_nt), .in_ready(in_ready_nt), .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid_nt), .out_ready(out_ready), .out_sym(out_sym_nt), .out_last(out_last_nt)
    );

    // Record every completed output handshake of the terminated instance
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back({out_last, out_sym});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic l);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_sym"},   32'(out_sym),   32'(s));
        check({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    // Called at a negedge; returns at the negedge after the bit was accepted
    task automatic send_bit(input logic b, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_count(input int n);
        int waited = 0;
        while (q.size() < n && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_count", 32'(q.size()), 32'(n));
    endtask

    task automatic check_stream_a(input string tag);
        for (int i = 0; i < 6; i++) begin
            if (i < q.size()) check($sformatf("%s_sym%0d", tag, i), 32'(q[i]), 32'(EXP_A[i]));
            else              check($sformatf("%s_missing%0d", tag, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        logic [3:0] bits_a;
        bits_a      = 4'b1101;
        rst         = 1'b1;
        enable      = 1'b1;
        out_ready   = 1'b1;
        in_valid    = 1'b0;
        in_valid_nt = 1'b0;
        in_bit      = 1'b0;
        in_last     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 1'b0, 2'b00, 1'b0);
        check("reset_sr", 32'(dut.sr), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Frame 1,0,1,1 at full rate: consecutive symbols, last only on the tail end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bit   = bits_a[i];
            in_last  = (i == 3);
            @(negedge clk);
            check_out($sformatf("a_bit%0d", i), 1'b1, EXP_A[i][1:0], 1'b0);
        end
        in_valid = 1'b0;
        #1;
        check("a_tail_rdy0", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_out("a_tail0", 1'b1, 2'b01, 1'b0);
        check("a_tail_rdy1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_out("a_tail1", 1'b1, 2'b11, 1'b1);
        @(negedge clk);
        check("a_idle_valid", 32'(out_valid), 32'd0);
        check("a_sr_zero", 32'(dut.sr), 32'd0);
        check("a_rdy_back", 32'(in_ready), 32'd1);

        // Single-bit frame, next frame offered immediately and accepted right after the tail
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_last  = 1'b1;
        @(negedge clk);
        check_out("b_data", 1'b1, 2'b11, 1'b0);
        check("b_rdy0", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_out("b_tail0", 1'b1, 2'b10, 1'b0);
        check("b_rdy1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_out("b_tail1", 1'b1, 2'b11, 1'b1);
        check("b_rdy2", 32'(in_ready), 32'd1);
        @(negedge clk);
        check_out("b_next", 1'b1, 2'b11, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check_out("b_next_t0", 1'b1, 2'b10, 1'b0);
        @(negedge clk);
        check_out("b_next_t1", 1'b1, 2'b11, 1'b1);
        @(negedge clk);

        // Output back-pressure for 3 cycles
        q.delete();
        send_bit(1'b1, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("c_rdy%0d", i), 32'(in_ready), 32'd0);
            @(negedge clk);
            check_out($sformatf("c_hold%0d", i), 1'b1, 2'b11, 1'b0);
        end
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        wait_count(6);
        check_stream_a("c");
        @(negedge clk);

        // enable low for 4 cycles mid-frame; pending symbol still drains
        q.delete();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("d_rdy%0d", i), 32'(in_ready), 32'd0);
            @(negedge clk);
            check($sformatf("d_drained%0d", i), 32'(out_valid), 32'd0);
        end
        check("d_count_paused", 32'(q.size()), 32'd2);
        enable = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        wait_count(6);
        check_stream_a("d");
        @(negedge clk);

        // Reset mid-frame, then a clean frame from state 0
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("e_rst_valid", 32'(out_valid), 32'd0);
        check("e_rst_sr", 32'(dut.sr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        wait_count(6);
        check_stream_a("e");
        check("e_sr_zero", 32'(dut.sr), 32'd0);

        // Unterminated instance: frame 1,1 then frame 1
        @(negedge clk);
        in_valid_nt = 1'b1;
        in_bit      = 1'b1;
        in_last     = 1'b0;
        #1;
        check("f_rdy", 32'(in_ready_nt), 32'd1);
        @(negedge clk);
        check("f_s0", 32'({out_valid_nt, out_last_nt, out_sym_nt}), 32'b1011);
        in_last = 1'b1;
        @(negedge clk);
        check("f_s1", 32'({out_valid_nt, out_last_nt, out_sym_nt}), 32'b1101);
        check("f_sr_clr", 32'(dut_nt.sr), 32'd0);
        @(negedge clk);
        check("f_next", 32'({out_valid_nt, out_last_nt, out_sym_nt}), 32'b1111);
        in_valid_nt = 1'b0;
        in_last     = 1'b0;
        @(negedge clk);
        check("f_idle", 32'(out_valid_nt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter K, default 3, constraint length (memory K-1 bits).
REQ-002 SHALL have parameter G0, default 3'b111 (octal 7), generator for out_sym[1].
REQ-003 SHALL have parameter G1, default 3'b101 (octal 5), generator for out_sym[0].
REQ-004 SHALL have parameter TERMINATE, default 1, where 1 means K-1 zero tail bits are appended per frame.
REQ-005 SHALL have port clk, input, 1 bit, clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset: asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit, which permits input acceptance and tail generation when high.
REQ-008 SHALL have port in_valid, input, 1 bit, asserting that in_bit/in_last are valid.
REQ-009 SHALL have port in_ready, output, 1 bit, indicating the encoder accepts an input bit this cycle.
REQ-010 SHALL have port in_bit, input, 1 bit, the information bit.
REQ-011 SHALL have port in_last, input, 1 bit, marking the final information bit of a frame.
REQ-012 SHALL have port out_valid, output, 1 bit, indicating out_sym/out_last are valid.
REQ-013 SHALL have port out_ready, input, 1 bit, indicating the downstream accepts the symbol.
REQ-014 SHALL have port out_sym, output, 2 bits, as {G0 parity, G1 parity}.
REQ-015 SHALL have port out_last, output, 1 bit, marking the final symbol of the frame.

Function
REQ-016 SHALL hold an encoder shift register sr[K-2:0], where sr[0] is the most recent previous bit.
REQ-017 SHALL form v = {u, sr[0], ..., sr[K-2]} with u at the MSB; out_sym[1] = XOR-reduce(G0 & v) and out_sym[0] = XOR-reduce(G1 & v).
REQ-018 SHALL, on each encoded bit, shift u into sr[0] and discard sr[K-2].
REQ-019 SHALL use one output register stage; "slot free" is defined as !out_valid || out_ready.
REQ-020 SHALL drive in_ready = enable && fsm==DATA && slot free; an input transfer is in_valid && in_ready.
REQ-021 SHALL register out_sym for an accepted input bit with out_valid=1 on the next cycle (latency 1), sustaining 1 symbol/cycle under continuous ready.
REQ-022 SHALL clear out_valid after out_valid && out_ready when no new symbol is loaded in the same cycle.
REQ-023 SHALL hold out_sym/out_last stable while out_valid && !out_ready.
REQ-024 SHALL complete output handshakes independently of enable; enable=0 blocks only new loads.
REQ-025 SHALL implement FSM states DATA (accept input) and TAIL (emit zero tail bits); the reset state is DATA.
REQ-026 SHALL, with TERMINATE=1 and an accepted in_last, encode that bit with out_last=0 and move DATA->TAIL with tail_cnt=0.
REQ-027 SHALL, in TAIL with enable && slot free, encode u=0, increment tail_cnt, and set out_last=1 on tail symbol K-1, then return to DATA.
REQ-028 SHALL leave sr at all zeros after the final tail bit (trellis terminated in state 0).
REQ-029 SHALL hold in_ready=0 throughout TAIL.
REQ-030 SHALL, with TERMINATE=0, set out_last=in_last on the symbol, clear sr to 0 on frame end, and not enter TAIL.
REQ-031 SHALL size tail_cnt as $clog2(K) bits; no wrap beyond K-1.
REQ-032 SHALL not require a gap between frames: the first bit of the next frame is accepted in the cycle after the last tail load.

Reset
REQ-033 SHALL, on asserting rst, immediately set sr=0, fsm=DATA, tail_cnt=0, out_valid=0, out_sym=0, out_last=0; in_ready follows combinationally.
REQ-034 SHALL discard a partial frame or tail when rst occurs mid-operation; the next frame starts from state 0.

Structure
REQ-035 SHALL place K, G0, G1 defaults, the FSM state enum and a parity(g, v) function in shared package viterbi_pkg, so the decoder branch-metric logic uses identical generators.
REQ-036 SHALL be a single module with no sub-modules; the FSM, shift register and output register are all in conv_encoder.

Verification
REQ-037 SHALL cover: bits 1,0,1,1 (last on 4th), out_ready=1 -> out_sym 11,10,00,01,01,11 on consecutive cycles, out_last only on 6th, sr=00 after.
REQ-038 SHALL cover: single-bit frame 1 with last -> 11,10,11, out_last on 3rd; in_ready=0 for 2 cycles after acceptance.
REQ-039 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> out_sym held constant, in_ready=0, no symbol lost or duplicated.
REQ-040 SHALL cover: enable=0 for 4 cycles mid-frame -> in_ready=0, pending output still drains, sequence resumes bit-exact after enable=1.
REQ-041 SHALL cover: rst pulsed after 2 bits of a frame -> out_valid=0 at once; new frame 1,0,1,1 reproduces the REQ-037 sequence.
REQ-042 SHALL cover: TERMINATE=0, bits 1,1 with last -> 11,01, out_last on 2nd; next frame 1 -> 11 (sr cleared).
